// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART parity engine
package uart_pkg;

    localparam int UART_MAX_LEN = 8;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_EVEN  = 3'd1,
        PAR_ODD   = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } parity_mode_e;

    typedef enum logic [1:0] {
        PE_IDLE,
        PE_DATA,
        PE_PAR,
        PE_DONE
    } par_state_e;

endpackage

// File: rtl/uart_parity_engine.sv
// rtl/uart_parity_engine.sv - serial bit-at-a-time parity generator/checker
module uart_parity_engine
    import uart_pkg::*;
#(
    parameter int MAX_LEN = UART_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [2:0]       mode_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    output logic             busy_o,
    output logic             par_ready_o,
    output logic             parity_bit_o,
    output logic             done_o,
    output logic             parity_err_o
);

    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

    par_state_e       r_state;
    parity_mode_e     r_mode;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic             r_acc;
    logic             r_err;

    par_state_e       w_state_nxt;
    parity_mode_e     w_mode_nxt;
    logic [LEN_W-1:0] w_len_nxt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic             w_acc_nxt;
    logic             w_err_nxt;
    logic             w_par_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= PE_IDLE;
            r_mode  <= PAR_NONE;
            r_len   <= MAX_LEN_W;
            r_cnt   <= '0;
            r_acc   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        unique case (r_mode)
            PAR_EVEN:  w_par_bit = r_acc;
            PAR_ODD:   w_par_bit = ~r_acc;
            PAR_MARK:  w_par_bit = 1'b1;
            default:   w_par_bit = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_err_nxt   = r_err;

        if (start_i) begin
            // Mode and length are normalised once here so the datapath never sees illegal values.
            w_mode_nxt  = (mode_i > 3'd4) ? PAR_NONE : parity_mode_e'(mode_i);
            w_len_nxt   = (len_i == '0 || len_i > MAX_LEN_W) ? MAX_LEN_W : len_i;
            w_cnt_nxt   = '0;
            w_acc_nxt   = 1'b0;
            w_err_nxt   = 1'b0;
            w_state_nxt = PE_DATA;
        end else begin
            unique case (r_state)
                PE_DATA: begin
                    if (bit_valid_i) begin
                        w_acc_nxt = r_acc ^ bit_i;
                        w_cnt_nxt = r_cnt + LEN_W'(1);
                        if (r_cnt == r_len - LEN_W'(1))
                            w_state_nxt = (r_mode == PAR_NONE) ? PE_DONE : PE_PAR;
                    end
                end
                PE_PAR: begin
                    if (bit_valid_i) begin
                        w_err_nxt   = (bit_i != w_par_bit);
                        w_state_nxt = PE_DONE;
                    end
                end
                PE_DONE: w_state_nxt = PE_IDLE;
                default: w_state_nxt = PE_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o       = (r_state != PE_IDLE);
        par_ready_o  = (r_state == PE_PAR);
        parity_bit_o = (r_state == PE_PAR) ? w_par_bit : 1'b0;
        done_o       = (r_state == PE_DONE);
        parity_err_o = r_err;
    end

endmodule

// File: tb/tb_uart_parity_engine.sv
// tb/tb_uart_parity_engine.sv - directed self-checking bench for uart_parity_engine
module tb_uart_parity_engine;

    logic       clk;
    logic       reset;
    logic       start_i;
    logic [2:0] mode_i;
    logic [3:0] len_i;
    logic       bit_valid_i;
    logic       bit_i;
    logic       busy_o;
    logic       par_ready_o;
    logic       parity_bit_o;
    logic       done_o;
    logic       parity_err_o;

    int checks;
    int failures;

    uart_parity_engine dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .len_i        (len_i),
        .bit_valid_i  (bit_valid_i),
        .bit_i        (bit_i),
        .busy_o       (busy_o),
        .par_ready_o  (par_ready_o),
        .parity_bit_o (parity_bit_o),
        .done_o       (done_o),
        .parity_err_o (parity_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are observed on the falling edge.
    task automatic do_start(input logic [2:0] mode, input logic [3:0] len);
        start_i = 1'b1;
        mode_i  = mode;
        len_i   = len;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic do_bit(input logic b);
        bit_valid_i = 1'b1;
        bit_i       = b;
        @(negedge clk);
        bit_valid_i = 1'b0;
        bit_i       = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_o, par_ready_o, parity_bit_o, done_o, parity_err_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=00000",
                     {busy_o, par_ready_o, parity_bit_o, done_o, parity_err_o});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_even;
        logic [7:0] d;
        d = 8'hA5;
        do_start(3'd1, 4'd8);
        for (int i = 0; i < 8; i++) begin
            do_bit(d[i]);
            if (i == 6) begin
                checks++;
                if (par_ready_o !== 1'b0) begin
                    failures++;
                    $display("FAIL even_early_par_ready got=%b want=0", par_ready_o);
                end
            end
        end
        checks++;
        if ({par_ready_o, parity_bit_o, done_o} !== 3'b100) begin
            failures++;
            $display("FAIL even_par_state got=%b want=100", {par_ready_o, parity_bit_o, done_o});
        end
        do_bit(1'b0);
        checks++;
        if ({done_o, parity_err_o, busy_o} !== 3'b101) begin
            failures++;
            $display("FAIL even_done got=%b want=101", {done_o, parity_err_o, busy_o});
        end
        @(negedge clk);
        checks++;
        if ({done_o, busy_o} !== 2'b00) begin
            failures++;
            $display("FAIL even_done_pulse_width got=%b want=00", {done_o, busy_o});
        end
    endtask

    task automatic test_odd_err;
        logic [6:0] d;
        d = 7'h01;
        do_start(3'd2, 4'd7);
        for (int i = 0; i < 7; i++) do_bit(d[i]);
        checks++;
        if ({par_ready_o, parity_bit_o} !== 2'b10) begin
            failures++;
            $display("FAIL odd_parity_bit got=%b want=10", {par_ready_o, parity_bit_o});
        end
        do_bit(1'b1);
        checks++;
        if ({done_o, parity_err_o} !== 2'b11) begin
            failures++;
            $display("FAIL odd_err got=%b want=11", {done_o, parity_err_o});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_o, parity_err_o} !== 2'b01) begin
            failures++;
            $display("FAIL odd_err_held got=%b want=01", {busy_o, parity_err_o});
        end
        do_start(3'd1, 4'd8);
        checks++;
        if ({busy_o, parity_err_o} !== 2'b10) begin
            failures++;
            $display("FAIL odd_err_cleared got=%b want=10", {busy_o, parity_err_o});
        end
    endtask

    task automatic test_none_modes;
        logic [2:0] modes [2];
        modes[0] = 3'd0;
        modes[1] = 3'b111;
        for (int m = 0; m < 2; m++) begin
            logic saw_par;
            saw_par = 1'b0;
            do_start(modes[m], 4'd5);
            for (int i = 0; i < 5; i++) begin
                do_bit(i[0]);
                if (par_ready_o) saw_par = 1'b1;
                if (i == 3) begin
                    checks++;
                    if (done_o !== 1'b0) begin
                        failures++;
                        $display("FAIL none_early_done mode=%0d got=%b want=0", modes[m], done_o);
                    end
                end
            end
            checks++;
            if ({done_o, saw_par, parity_err_o} !== 3'b100) begin
                failures++;
                $display("FAIL none_done mode=%0d got=%b want=100", modes[m],
                         {done_o, saw_par, parity_err_o});
            end
            @(negedge clk);
            checks++;
            if ({done_o, busy_o} !== 2'b00) begin
                failures++;
                $display("FAIL none_idle mode=%0d got=%b want=00", modes[m], {done_o, busy_o});
            end
        end
    endtask

    task automatic test_mark_space;
        logic [7:0] d;
        d = 8'h37;
        do_start(3'd3, 4'd0);
        for (int i = 0; i < 8; i++) begin
            do_bit(d[i]);
            if (i == 6) begin
                checks++;
                if (par_ready_o !== 1'b0) begin
                    failures++;
                    $display("FAIL mark_len0_early got=%b want=0", par_ready_o);
                end
            end
        end
        checks++;
        if ({par_ready_o, parity_bit_o} !== 2'b11) begin
            failures++;
            $display("FAIL mark_parity got=%b want=11", {par_ready_o, parity_bit_o});
        end
        do_bit(1'b1);
        checks++;
        if ({done_o, parity_err_o} !== 2'b10) begin
            failures++;
            $display("FAIL mark_done got=%b want=10", {done_o, parity_err_o});
        end
        @(negedge clk);
        d = 8'hFF;
        do_start(3'd4, 4'd0);
        for (int i = 0; i < 8; i++) do_bit(d[i]);
        checks++;
        if ({par_ready_o, parity_bit_o} !== 2'b10) begin
            failures++;
            $display("FAIL space_parity got=%b want=10", {par_ready_o, parity_bit_o});
        end
        do_bit(1'b1);
        checks++;
        if ({done_o, parity_err_o} !== 2'b11) begin
            failures++;
            $display("FAIL space_err got=%b want=11", {done_o, parity_err_o});
        end
        @(negedge clk);
    endtask

    task automatic test_restart_mid_frame;
        logic saw_done;
        logic [3:0] d;
        saw_done = 1'b0;
        d = 4'b0001;
        do_start(3'd1, 4'd8);
        for (int i = 0; i < 3; i++) do_bit(1'b1);
        start_i     = 1'b1;
        mode_i      = 3'd1;
        len_i       = 4'd4;
        bit_valid_i = 1'b1;
        bit_i       = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
        bit_valid_i = 1'b0;
        bit_i       = 1'b0;
        checks++;
        if ({busy_o, done_o, par_ready_o} !== 3'b100) begin
            failures++;
            $display("FAIL restart_state got=%b want=100", {busy_o, done_o, par_ready_o});
        end
        for (int i = 0; i < 4; i++) begin
            do_bit(d[i]);
            if (done_o) saw_done = 1'b1;
            if (i == 2) begin
                checks++;
                if (par_ready_o !== 1'b0) begin
                    failures++;
                    $display("FAIL restart_cnt_early got=%b want=0", par_ready_o);
                end
            end
        end
        checks++;
        if ({par_ready_o, parity_bit_o, saw_done} !== 3'b110) begin
            failures++;
            $display("FAIL restart_par got=%b want=110", {par_ready_o, parity_bit_o, saw_done});
        end
        do_bit(1'b1);
        checks++;
        if ({done_o, parity_err_o} !== 2'b10) begin
            failures++;
            $display("FAIL restart_done got=%b want=10", {done_o, parity_err_o});
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        logic saw_busy;
        saw_busy = 1'b0;
        do_start(3'd2, 4'd5);
        for (int i = 0; i < 5; i++) do_bit(1'b0);
        checks++;
        if ({par_ready_o, parity_bit_o} !== 2'b11) begin
            failures++;
            $display("FAIL areset_pre got=%b want=11", {par_ready_o, parity_bit_o});
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy_o, par_ready_o, parity_bit_o, done_o, parity_err_o} !== 5'b0) begin
            failures++;
            $display("FAIL areset_immediate got=%b want=00000",
                     {busy_o, par_ready_o, parity_bit_o, done_o, parity_err_o});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_bit(1'b1);
            if (busy_o || done_o) saw_busy = 1'b1;
        end
        checks++;
        if ({saw_busy, parity_err_o} !== 2'b00) begin
            failures++;
            $display("FAIL areset_idle_ignores_bits got=%b want=00", {saw_busy, parity_err_o});
        end
        do_start(3'd0, 4'd1);
        do_bit(1'b1);
        checks++;
        if (done_o !== 1'b1) begin
            failures++;
            $display("FAIL areset_recover got=%b want=1", done_o);
        end
        @(negedge clk);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        start_i     = 1'b0;
        mode_i      = 3'd0;
        len_i       = 4'd0;
        bit_valid_i = 1'b0;
        bit_i       = 1'b0;
        @(negedge clk);
        test_reset();
        test_even();
        test_odd_err();
        test_none_modes();
        test_mark_space();
        test_restart_mid_frame();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
